conv_stream_block: RTL and testbench

// - Parametrised successor to the fixed 6x6/3x3 convolution front end: streams an n x n fixed-point feature map
//   in raster order, one pixel per accepted beat, and emits the k x k strided valid-convolution result.
// - Adds a runtime weight-load port, a valid/ready input handshake, stride > 1, and saturating output.
// - Feeds the pooling and linear stages downstream; one instance per input channel.

---
 rtl/conv_stream_block.sv | 185 ++++++++++++++++++
 tb/tb_conv_stream_block.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv_stream_block.sv
// conv_stream_block -- streaming k x k strided valid-convolution front end.
//
// Streams an n x n two's-complement Q-format feature map in raster order (one
// pixel per accepted beat) and emits the m x m convolution result, m = (n-k)/s+1.
// Weights are loaded at runtime, row-major, k*k words per set, and are retained
// across frames.
//
// Optional build macro: RELU_EN -- when defined, negative saturated results are
// clamped to zero. Latency is the same in both builds.
//
// Ports:
//   clk           clock, rising edge
//   global_rst_n  asynchronous active-low reset
//   ce            streaming clock enable (low = stall)
//   w_load/w_data weight word strobe / word (accepted in IDLE/LOAD only)
//   act_valid     activation beat present
//   activation    activation pixel
//   act_ready     activation accepted this cycle when act_valid is high
//   conv_out      saturated Q-format result
//   conv_valid    one-cycle pulse per result
//   conv_end      marks the m*m-th result of a frame
//   weights_ok    a complete weight set is held

// Signed N x N multiplier for one kernel tap; full 2N-bit product.
module conv_tap_mul #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  logic signed [2*N-1:0] ae, be;
  assign ae = {{N{a[N-1]}}, a};
  assign be = {{N{b[N-1]}}, b};
  assign p  = ae * be;
endmodule

module conv_stream_block #(
  parameter int n = 6,
  parameter int k = 3,
  parameter int s = 1,
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         ce,
  input  logic         w_load,
  input  logic [N-1:0] w_data,
  input  logic         act_valid,
  input  logic [N-1:0] activation,
  output logic         act_ready,
  output logic [N-1:0] conv_out,
  output logic         conv_valid,
  output logic         conv_end,
  output logic         weights_ok
);
  localparam int K2 = k * k;
  localparam int L  = (k - 1) * n + k;
  localparam int M  = (n - k) / s + 1;
  localparam int SW = 2 * N + $clog2(K2);
  localparam int RW = $clog2(n);
  localparam int IW = $clog2(K2);
  localparam int OW = $clog2(M * M + 1);

  localparam logic signed [SW-1:0] MAXV = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} st_t;
  st_t st, st_nx;

  logic [K2-1:0][N-1:0]   wts;
  logic [L-1:0][N-1:0]    win, win_nx;
  logic [K2-1:0][2*N-1:0] prod;
  logic [RW-1:0]          r, c;
  logic [IW-1:0]          widx;
  logic [OW-1:0]          oc;
  logic                   accept, w_we, last_w, last_px, oc_last, out_hit;
  logic signed [SW-1:0]   acc, shd;
  logic [N-1:0]           res, res_o;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) st <= IDLE;
    else               st <= st_nx;

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (w_load) st_nx = LOAD;
               else if (ce && weights_ok) st_nx = RUN;
      LOAD:    if (w_load && last_w) st_nx = IDLE;
      RUN:     if (accept && last_px) st_nx = DONE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    act_ready = 1'b0;
    w_we      = 1'b0;
    case (st)
      IDLE, LOAD: w_we = w_load;
      RUN:        act_ready = ce;
      default:    ;
    endcase
  end

  assign accept  = act_valid && act_ready;
  assign last_w  = widx == IW'(K2 - 1);
  assign last_px = (r == RW'(n - 1)) && (c == RW'(n - 1));
  assign oc_last = oc == OW'(M * M - 1);

  // Window including the pixel being accepted: newest at index 0, so tap
  // (i,j) of the kernel sits (k-1-i) rows and (k-1-j) columns back.
  assign win_nx = {win[L-2:0], activation};

  // A result is due when the incoming pixel is the bottom-right corner of a
  // stride-aligned window.
  always_comb
    out_hit = accept &&
              (int'(r) >= k - 1) && (int'(c) >= k - 1) &&
              ((int'(r) - (k - 1)) % s == 0) &&
              ((int'(c) - (k - 1)) % s == 0);

  // ---------------- MAC ----------------
  for (genvar i = 0; i < k; i++) begin : g_row
    for (genvar j = 0; j < k; j++) begin : g_col
      conv_tap_mul #(.N(N)) u_tap (
        .a (win_nx[(k-1-i)*n + (k-1-j)]),
        .b (wts[i*k + j]),
        .p (prod[i*k + j])
      );
    end
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < K2; t++) acc = acc + SW'($signed(prod[t]));
    shd = acc >>> Q;  // floor toward -inf
    if (shd > MAXV)      res = MAXV[N-1:0];
    else if (shd < MINV) res = MINV[N-1:0];
    else                 res = shd[N-1:0];
`ifdef RELU_EN
    res_o = res[N-1] ? '0 : res;
`else
    res_o = res;
`endif
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      wts        <= '0;
      widx       <= '0;
      weights_ok <= 1'b0;
      win        <= '0;
      r          <= '0;
      c          <= '0;
      oc         <= '0;
      conv_out   <= '0;
      conv_valid <= 1'b0;
      conv_end   <= 1'b0;
    end else begin
      if (w_we) begin
        wts[widx]  <= w_data;
        widx       <= last_w ? '0 : widx + IW'(1);
        weights_ok <= last_w;  // first word of a new set drops it
      end
      if (accept) begin
        win <= win_nx;
        if (c == RW'(n - 1)) begin
          c <= '0;
          r <= last_px ? '0 : r + RW'(1);
        end else begin
          c <= c + RW'(1);
        end
      end
      conv_valid <= out_hit;
      conv_end   <= out_hit && oc_last;
      if (out_hit) begin
        conv_out <= res_o;
        oc       <= oc_last ? '0 : oc + OW'(1);
      end
    end
endmodule

// File: tb/tb_conv_stream_block.sv
// Directed bench for conv_stream_block: n=6, k=3, Q=12. A stride-1 and a
// stride-2 instance share the same stimulus; results are collected into
// queues and compared against hand-computed values.
module tb_conv_stream_block;
  logic        clk, global_rst_n, ce, w_load, act_valid;
  logic [15:0] w_data, activation;
  logic        rdy1, cv1, ce1, wok1, rdy2, cv2, ce2, wok2;
  logic [15:0] co1, co2;
  int          nchk = 0, nerr = 0;
  logic [16:0] q1[$], q2[$];

  conv_stream_block #(.n(6), .k(3), .s(1), .N(16), .Q(12)) u_s1 (
    .clk(clk), .global_rst_n(global_rst_n), .ce(ce), .w_load(w_load),
    .w_data(w_data), .act_valid(act_valid), .activation(activation),
    .act_ready(rdy1), .conv_out(co1), .conv_valid(cv1), .conv_end(ce1),
    .weights_ok(wok1));

  conv_stream_block #(.n(6), .k(3), .s(2), .N(16), .Q(12)) u_s2 (
    .clk(clk), .global_rst_n(global_rst_n), .ce(ce), .w_load(w_load),
    .w_data(w_data), .act_valid(act_valid), .activation(activation),
    .act_ready(rdy2), .conv_out(co2), .conv_valid(cv2), .conv_end(ce2),
    .weights_ok(wok2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cv1) q1.push_back({ce1, co1});
    if (cv2) q2.push_back({ce2, co2});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wv(input int kind, input int j);
    case (kind)
      0:       wv = (j == 4) ? 16'h1000 : 16'h0000;
      1:       wv = 16'h1000;
      default: wv = 16'hF000;
    endcase
  endfunction

  function automatic logic [15:0] pix(input int kind, input int i);
    case (kind)
      0:       pix = 16'(i * 16);
      1:       pix = 16'h1000;
      default: pix = 16'h0800;
    endcase
  endfunction

  task automatic load_w(input int kind, input int pause_at);
    for (int j = 0; j < 9; j++) begin
      if (pause_at > 0 && j == pause_at) begin
        @(negedge clk); w_load = 1'b0;
        #1 chk("wok_partial", wok1, 0);
        @(negedge clk);
      end
      @(negedge clk); w_load = 1'b1; w_data = wv(kind, j);
    end
    @(negedge clk); w_load = 1'b0;
    #1 chk("wok_load", wok1, 1);
  endtask

  task automatic run_frame(input int kind, input bit stall, input int lim);
    int i = 0, cyc = 0, hold = 3;
    q1.delete(); q2.delete();
    while (i < lim && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stall && i == 8 && hold > 0) begin ce = 1'b0; hold--; end
      else ce = 1'b1;
      act_valid  = !(stall && (cyc % 3 == 0));
      activation = pix(kind, i);
      #1;
      if (stall && !ce) chk("rdy_stall", rdy1, 0);
      if (stall && ce && i == 8 && hold == 0) chk("rdy_resume", rdy1, 1);
      if (act_valid && rdy1) i++;
    end
    if (i < lim) chk("frame_timeout", i, lim);
    @(negedge clk); ce = 1'b0; act_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // stride-1 results: 4x4, kind 0 = identity on ramp, else constant cval
  task automatic chk_q1(input string tag, input int kind, input logic [15:0] cval);
    logic [15:0] e;
    int idx;
    chk({tag, "_cnt"}, q1.size(), 16);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        idx = a * 4 + b;
        e = (kind == 0) ? 16'(((a + 1) * 6 + b + 1) * 16) : cval;
        if (idx < q1.size()) begin
          chk(tag, q1[idx][15:0], e);
          chk({tag, "_end"}, q1[idx][16], idx == 15);
        end
      end
  endtask

  initial begin
    logic [15:0] s2e[4];
    logic [15:0] negv;
    s2e[0] = 16'h0070; s2e[1] = 16'h0090; s2e[2] = 16'h0130; s2e[3] = 16'h0150;
`ifdef RELU_EN
    negv = 16'h0000;
`else
    negv = 16'hB800;
`endif
    global_rst_n = 1'b0; ce = 1'b0; w_load = 1'b0; w_data = '0;
    act_valid = 1'b0; activation = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy1, 0);
    chk("rst_valid", cv1, 0);
    chk("rst_out", co1, 0);
    chk("rst_end", ce1, 0);
    chk("rst_wok", wok1, 0);
    global_rst_n = 1'b1;
    @(negedge clk);

    // identity kernel, ramp, unstalled; both strides
    load_w(0, 0);
    run_frame(0, 1'b0, 36); settle();
    chk_q1("ident", 0, 16'h0);
    chk("s2_cnt", q2.size(), 4);
    for (int t = 0; t < 4; t++)
      if (t < q2.size()) begin
        chk("s2_val", q2[t][15:0], s2e[t]);
        chk("s2_end", q2[t][16], t == 3);
      end

    // same frame with ce stalls and act_valid gaps
    run_frame(0, 1'b1, 36); settle();
    chk_q1("stall", 0, 16'h0);

    // positive saturation; partial load keeps weights_ok low
    load_w(1, 4);
    run_frame(1, 1'b0, 36); settle();
    chk_q1("satp", 1, 16'h7FFF);

    // negative result (-4.5)
    load_w(2, 0);
    run_frame(2, 1'b0, 36); settle();
    chk_q1("neg", 1, negv);

    // reset mid-frame
    load_w(0, 0);
    run_frame(0, 1'b0, 20);
    global_rst_n = 1'b0;
    #1;
    chk("mrst_out", co1, 0);
    chk("mrst_valid", cv1, 0);
    chk("mrst_end", ce1, 0);
    chk("mrst_wok", wok1, 0);
    chk("mrst_ready", rdy1, 0);
    repeat (2) @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_wok_after", wok1, 0);
    load_w(0, 0);
    run_frame(0, 1'b0, 36); settle();
    chk_q1("reload", 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
